// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the router output-stage arbiter.
// Flit type codes, FSM states and the state-to-select decode.
package mux_arbiter_pkg;

  localparam int TYPEW = 2;

  localparam logic [TYPEW-1:0] TYPE_NONE = 2'b00;
  localparam logic [TYPEW-1:0] TYPE_HEAD = 2'b01;
  localparam logic [TYPEW-1:0] TYPE_DATA = 2'b10;
  localparam logic [TYPEW-1:0] TYPE_TAIL = 2'b11;

  localparam logic High    = 1'b1;
  localparam logic Enable_ = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  function automatic logic [1:0] sel_of(state_t s);
    logic [1:0] r;
    r = 2'b00;
    unique case (s)
      LOCK0:   r = 2'b01;
      LOCK1:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_arb2.sv
// Two-requester round-robin picker: one-hot grant from req and ptr.
// Ports: req_i[1:0], ptr_i (preferred port on a tie), gnt_o[1:0].
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = req_i[0] & (~req_i[1] | ~ptr_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] |  ptr_i);

endmodule

// File: rtl/mux_arbiter.sv
// Packet-level round-robin arbiter driving the 2:1 output mux select.
// Ports: clk, rst_, idata/ivalid x2, oready, clr -> sel, iready x2, pkt_cnt x2, err.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATAW = 36,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata_0,
  input  logic             ivalid_0,
  input  logic [DATAW-1:0] idata_1,
  input  logic             ivalid_1,
  input  logic             oready,
  input  logic             clr,
  output logic [1:0]       sel,
  output logic             iready_0,
  output logic             iready_1,
  output logic [CNTW-1:0]  pkt_cnt_0,
  output logic [CNTW-1:0]  pkt_cnt_1,
  output logic             err
);

  logic [TYPEW-1:0] ty0, ty1;
  logic             unused_payload;

  assign ty0 = idata_0[DATAW-1 -: TYPEW];
  assign ty1 = idata_1[DATAW-1 -: TYPEW];
  assign unused_payload =
    ^{idata_0[DATAW-TYPEW-1:0], idata_1[DATAW-TYPEW-1:0]};

  state_t          state_q, state_d;
  logic [1:0]      sel_q;
  logic            ptr_q, ptr_d;
  logic            first_q, first_d;
  logic [CNTW-1:0] cnt0_q, cnt1_q;
  logic            err_q, err_ev;

  logic       head0, head1;
  logic       x0, x1;
  logic       tail0, tail1;
  logic [1:0] gnt;

  assign head0 = ivalid_0 & (ty0 == TYPE_HEAD);
  assign head1 = ivalid_1 & (ty1 == TYPE_HEAD);

  assign iready_0 = sel_q[0] & oready;
  assign iready_1 = sel_q[1] & oready;
  assign x0 = iready_0 & ivalid_0;
  assign x1 = iready_1 & ivalid_1;
  assign tail0 = x0 & (ty0 == TYPE_TAIL);
  assign tail1 = x1 & (ty1 == TYPE_TAIL);

  rr_arb2 u_rr (
    .req_i ({head1, head0}),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    err_ev  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // DATA and TAIL codes both have the upper type bit set
        err_ev  = (ivalid_0 & ty0[1]) | (ivalid_1 & ty1[1]);
        first_d = |gnt;
        if (gnt[0])      state_d = LOCK0;
        else if (gnt[1]) state_d = LOCK1;
      end
      LOCK0: begin
        if (x0) begin
          first_d = 1'b0;
          err_ev  = ((ty0 == TYPE_HEAD) & ~first_q)
                  | (ty0 == TYPE_NONE);
          if (tail0) begin
            ptr_d   = 1'b1;
            first_d = High;
            if (head1)      state_d = LOCK1;
            else if (head0) state_d = LOCK0;
            else begin
              state_d = IDLE;
              first_d = 1'b0;
            end
          end
        end
      end
      LOCK1: begin
        if (x1) begin
          first_d = 1'b0;
          err_ev  = ((ty1 == TYPE_HEAD) & ~first_q)
                  | (ty1 == TYPE_NONE);
          if (tail1) begin
            ptr_d   = 1'b0;
            first_d = High;
            if (head0)      state_d = LOCK0;
            else if (head1) state_d = LOCK1;
            else begin
              state_d = IDLE;
              first_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == Enable_) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      ptr_q   <= 1'b0;
      first_q <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_of(state_d);
      ptr_q   <= ptr_d;
      first_q <= first_d;
      if (clr) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
        err_q  <= 1'b0;
      end else begin
        cnt0_q <= cnt0_q + {{(CNTW-1){1'b0}}, tail0};
        cnt1_q <= cnt1_q + {{(CNTW-1){1'b0}}, tail1};
        err_q  <= err_q | err_ev;
      end
    end
  end

  assign sel       = sel_q;
  assign pkt_cnt_0 = cnt0_q;
  assign pkt_cnt_1 = cnt1_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus random
// packet traffic compared cycle by cycle against a behavioural model.
module tb_mux_arbiter;

  localparam int DATAW = 36;
  localparam int CNTW  = 4;
  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;
  localparam logic [1:0] T_TAIL = 2'd3;

  logic             clk = 1'b0;
  logic             rst_;
  logic [DATAW-1:0] idata_0, idata_1;
  logic             ivalid_0, ivalid_1;
  logic             oready, clr;
  logic [1:0]       sel;
  logic             iready_0, iready_1;
  logic [CNTW-1:0]  pkt_cnt_0, pkt_cnt_1;
  logic             err;

  mux_arbiter #(.DATAW(DATAW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .idata_0   (idata_0),
    .ivalid_0  (ivalid_0),
    .idata_1   (idata_1),
    .ivalid_1  (ivalid_1),
    .oready    (oready),
    .clr       (clr),
    .sel       (sel),
    .iready_0  (iready_0),
    .iready_1  (iready_1),
    .pkt_cnt_0 (pkt_cnt_0),
    .pkt_cnt_1 (pkt_cnt_1),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model: owner of the lock (-1 none), tie pointer, counts, error
  int m_g;
  bit m_ptr, m_first, m_err;
  int m_c[2];
  bit m_x[2];
  int dut_x[2];

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  task automatic vchk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_g = -1; m_ptr = 0; m_first = 0; m_err = 0;
    m_c[0] = 0; m_c[1] = 0; m_x[0] = 0; m_x[1] = 0;
  endtask

  task automatic m_step(input bit v0, input logic [1:0] t0,
                        input bit v1, input logic [1:0] t1,
                        input bit ordy, input bit c);
    bit v[2];
    logic [1:0] t[2];
    bit ev;
    int ng, n, o;
    v[0] = v0; v[1] = v1; t[0] = t0; t[1] = t1;
    ev = 0; ng = m_g;
    for (int i = 0; i < 2; i++) m_x[i] = (m_g == i) && v[i] && ordy;
    if (m_g < 0) begin
      for (int i = 0; i < 2; i++)
        if (v[i] && (t[i] == T_DATA || t[i] == T_TAIL)) ev = 1;
      if (v[0] && t[0] == T_HEAD && v[1] && t[1] == T_HEAD) ng = int'(m_ptr);
      else if (v[0] && t[0] == T_HEAD) ng = 0;
      else if (v[1] && t[1] == T_HEAD) ng = 1;
      m_first = (ng >= 0);
    end else begin
      n = m_g; o = 1 - n;
      if (m_x[n]) begin
        if ((t[n] == T_HEAD && !m_first) || t[n] == T_NONE) ev = 1;
        m_first = 0;
        if (t[n] == T_TAIL) begin
          m_c[n] = (m_c[n] + 1) % (1 << CNTW);
          m_ptr = (o == 1);
          if (v[o] && t[o] == T_HEAD) begin
            ng = o; m_first = 1;
          end else ng = -1;
        end
      end
    end
    m_g = ng;
    if (c) begin
      m_err = 0; m_c[0] = 0; m_c[1] = 0;
    end else m_err = m_err | ev;
  endtask

  task automatic cyc(input bit v0, input logic [1:0] t0,
                     input bit v1, input logic [1:0] t1,
                     input bit ordy, input bit c);
    @(negedge clk);
    ivalid_0 = v0; idata_0 = {t0, (DATAW-2)'($urandom)};
    ivalid_1 = v1; idata_1 = {t1, (DATAW-2)'($urandom)};
    oready = ordy; clr = c;
    #1;
    vchk("sel", sel, m_g == 0 ? 1 : (m_g == 1 ? 2 : 0));
    vchk("iready_0", iready_0, (m_g == 0) && ordy);
    vchk("iready_1", iready_1, (m_g == 1) && ordy);
    vchk("pkt_cnt_0", pkt_cnt_0, m_c[0]);
    vchk("pkt_cnt_1", pkt_cnt_1, m_c[1]);
    vchk("err", err, m_err);
    dut_x[0] += int'(iready_0 & ivalid_0);
    dut_x[1] += int'(iready_1 & ivalid_1);
    @(posedge clk);
    m_step(v0, t0, v1, t1, ordy, c);
  endtask

  task automatic idle(input bit c);
    cyc(0, T_NONE, 0, T_NONE, 1, c);
  endtask

  task automatic push_pkt(input int port, input int ndata);
    if (port == 0) begin
      q0.push_back(T_HEAD);
      for (int i = 0; i < ndata; i++) q0.push_back(T_DATA);
      q0.push_back(T_TAIL);
    end else begin
      q1.push_back(T_HEAD);
      for (int i = 0; i < ndata; i++) q1.push_back(T_DATA);
      q1.push_back(T_TAIL);
    end
  endtask

  // op < 0 toggles oready 1,0,1,0...; junk flits are never popped
  task automatic pump(input int maxc, input int vp, input int op,
                      input int jp, input int cp);
    int cy;
    bit v0, v1, o, c, j0, j1;
    logic [1:0] t0, t1;
    cy = 0;
    while ((q0.size() > 0 || q1.size() > 0) && cy < maxc) begin
      v0 = (q0.size() > 0) && ($urandom_range(99) < vp);
      t0 = (q0.size() > 0) ? q0[0] : T_NONE;
      v1 = (q1.size() > 0) && ($urandom_range(99) < vp);
      t1 = (q1.size() > 0) ? q1[0] : T_NONE;
      j0 = (q0.size() > 0) && ($urandom_range(99) < jp);
      j1 = (q1.size() > 0) && ($urandom_range(99) < jp);
      if (j0) begin v0 = 1; t0 = 2'($urandom_range(2)); end
      if (j1) begin v1 = 1; t1 = 2'($urandom_range(2)); end
      o = (op < 0) ? (cy % 2 == 0) : ($urandom_range(99) < op);
      c = ($urandom_range(99) < cp);
      cyc(v0, t0, v1, t1, o, c);
      if (m_x[0] && !j0) void'(q0.pop_front());
      if (m_x[1] && !j1) void'(q1.pop_front());
      cy++;
    end
    vchk("drain", q0.size() + q1.size(), 0);
    q0.delete(); q1.delete();
  endtask

  initial begin
    rst_ = 1'b0; clr = 0; oready = 0;
    ivalid_0 = 0; ivalid_1 = 0; idata_0 = '0; idata_1 = '0;
    m_reset();
    dut_x[0] = 0; dut_x[1] = 0;
    #1;
    vchk("rst_sel", sel, 0);
    vchk("rst_cnt0", pkt_cnt_0, 0);
    vchk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    idle(0);

    // single packet on port 1
    dut_x[1] = 0;
    push_pkt(1, 20);
    pump(200, 100, 100, 0, 0);
    idle(0);
    vchk("p1_xfers", dut_x[1], 22);
    vchk("p1_cnt", pkt_cnt_1, 1);
    idle(0);

    // simultaneous heads, twice
    push_pkt(0, 2); push_pkt(1, 2);
    pump(200, 100, 100, 0, 0);
    push_pkt(0, 1); push_pkt(1, 1);
    pump(200, 100, 100, 0, 0);
    idle(0);

    // back-pressure on port 0
    idle(1);
    dut_x[0] = 0;
    push_pkt(0, 20);
    pump(200, 100, -1, 0, 0);
    idle(0);
    vchk("bp_xfers", dut_x[0], 22);
    vchk("bp_cnt", pkt_cnt_0, 1);

    // protocol error in IDLE, then clear
    cyc(0, T_NONE, 1, T_DATA, 1, 0);
    #1;
    vchk("perr_err", err, 1);
    vchk("perr_ir1", iready_1, 0);
    vchk("perr_sel", sel, 0);
    idle(1);
    #1;
    vchk("clr_err", err, 0);

    // counter wrap
    for (int i = 0; i < 16; i++) begin
      push_pkt(0, 1);
      pump(50, 100, 100, 0, 0);
      #1;
      vchk("wrap", pkt_cnt_0, (i + 1) % 16);
    end

    // reset in the middle of a packet
    push_pkt(1, 0);
    pump(50, 100, 100, 0, 0);
    cyc(1, T_HEAD, 0, T_NONE, 1, 0);
    cyc(1, T_HEAD, 0, T_NONE, 1, 0);
    cyc(1, T_DATA, 0, T_NONE, 1, 0);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    vchk("mid_rst_sel", sel, 0);
    vchk("mid_rst_cnt0", pkt_cnt_0, 0);
    vchk("mid_rst_cnt1", pkt_cnt_1, 0);
    m_reset();
    ivalid_0 = 0; ivalid_1 = 0;
    @(negedge clk);
    rst_ = 1'b1;
    cyc(0, T_NONE, 1, T_HEAD, 1, 0);
    #1;
    vchk("regrant", sel, 2);
    cyc(0, T_NONE, 1, T_HEAD, 1, 0);
    cyc(0, T_NONE, 1, T_TAIL, 1, 0);
    idle(0);

    // random traffic with junk flits and occasional clears
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(3) != 0) push_pkt(0, $urandom_range(4));
      if ($urandom_range(3) != 0) push_pkt(1, $urandom_range(4));
      pump(400, 70, 70, 4, 2);
      if ($urandom_range(1) == 0) idle(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Packet-level round-robin arbiter that drives the one-hot `sel` input of the 2-to-1 router output mux.
- Once a HEAD flit is granted, the grant is held for the whole packet (wormhole lock) and released only after the TAIL flit transfers.
- Adds a downstream `oready` handshake, per-port ready back-pressure, per-port packet counters and a sticky protocol-error flag.
- Sits beside `mux` in the router output stage; `sel` connects directly to `mux.sel`.

Parameters:
- DATAW, 36, flit width; the flit type occupies bits [DATAW-1:DATAW-2].
- CNTW, 16, width of each per-port packet counter.

Ports:
- clk  in  1  system clock
- rst_  in  1  reset, asynchronous, active-low
- idata_0  in  DATAW  port 0 flit (only the type field is used)
- ivalid_0  in  1  port 0 flit valid
- idata_1  in  DATAW  port 1 flit
- ivalid_1  in  1  port 1 flit valid
- oready  in  1  downstream can accept a flit this cycle
- sel  out  2  one-hot mux select (01 = port 0, 10 = port 1, 00 = none)
- iready_0  out  1  port 0 flit accepted this cycle
- iready_1  out  1  port 1 flit accepted this cycle
- pkt_cnt_0  out  CNTW  packets completed from port 0
- pkt_cnt_1  out  CNTW  packets completed from port 1
- err  out  1  sticky protocol error
- clr  in  1  synchronous clear of counters and `err`

Behaviour:
- Flit types: NONE=00, HEAD=01, DATA=10, TAIL=11.
- Reset (asynchronous, rst_=0) forces:
  - state=IDLE, sel=00, rr_ptr=0 (port 0 has priority first);
  - pkt_cnt_0=0, pkt_cnt_1=0, err=0.
- A transfer on port n occurs when sel[n] & ivalid_n & oready.
- iready_n = sel[n] & oready. This is combinational and is 0 whenever sel[n]=0.
- FSM states: IDLE, LOCK0, LOCK1. `sel` is registered and decoded from state (LOCK0→01, LOCK1→10, IDLE→00).
- IDLE:
  - A request on port n is ivalid_n & type==HEAD.
  - With a single request, go to LOCKn.
  - With both requesting, grant the port at rr_ptr.
  - Grant latency is 1 cycle: a HEAD presented at edge k is granted (sel set) after edge k+1, and transfers from that cycle onward.
- LOCKn:
  - Stay in LOCKn while no TAIL has transferred; stalls (ivalid_n=0 or oready=0) hold the lock indefinitely.
  - When a TAIL transfers on port n:
    - pkt_cnt_n increments, wrapping at 2^CNTW-1 → 0;
    - rr_ptr becomes the other port;
    - the next state is decided in the same cycle: if the other port has a HEAD valid, go straight to LOCK(other), giving zero idle cycles between packets; else if port n has a HEAD valid, go to LOCKn; else go to IDLE.
- Protocol errors (set err=1, sticky until clr or reset):
  - a DATA or TAIL flit valid on a port while it is not granted and the FSM is IDLE; the flit is not consumed;
  - a HEAD flit transferred while in LOCKn after the lock's first flit; it is forwarded as data and does not release the lock;
  - a NONE flit transferred while locked; it is forwarded and does not release the lock.
- clr=1:
  - counters and err go to 0 next edge;
  - clr takes precedence over a simultaneous increment or error;
  - FSM and rr_ptr are unaffected.
- Reset mid-packet: the lock is dropped immediately (sel=00). Upstream is expected to restart packets after reset.
- Counter width rule: CNTW-bit unsigned, wrap-around with no saturation.

Decomposition:
- Shared package holds:
  - flit type constants (TYPE_NONE/HEAD/DATA/TAIL);
  - TYPEW=2 and the type-field slice macro;
  - state encodings IDLE/LOCK0/LOCK1;
  - `High`/`Enable_` style constants.
- One natural sub-module: rr_arb2, a 2-requester round-robin picker (req[1:0], ptr → one-hot gnt), reused later for wider ports.
- Counters and error logic stay in mux_arbiter.

Test Plan:
- Single packet, port 1 only, oready=1:
  - Stimulus: HEAD, 20×DATA, TAIL.
  - Response: sel=10 one cycle after HEAD valid; iready_1=1 for 22 transfers; sel=00 the cycle after TAIL; pkt_cnt_1=1.
- Simultaneous HEADs after reset:
  - Response: port 0 is granted first (sel=01).
  - After port 0's TAIL transfers, sel=10 with no IDLE cycle between packets.
  - After port 1's TAIL, port 0 wins the next tie.
- Back-pressure:
  - Stimulus: oready toggles 1,0,1,0 during a packet on port 0.
  - Response: iready_0 mirrors oready; the lock holds; exactly 22 transfers occur; pkt_cnt_0=1.
- Protocol error:
  - Stimulus: DATA flit valid on port 1 while IDLE.
  - Response: err=1, iready_1=0, sel=00.
  - Then pulse clr → err=0 next cycle.
- Reset mid-packet:
  - Stimulus: assert rst_=0 during DATA flits of a port 0 packet.
  - Response: sel=00 and counters=0 immediately (asynchronously).
  - After release, a new HEAD on port 1 is granted within 1 cycle.
- Counter wrap:
  - Stimulus: CNTW=4, send 16 one-DATA packets on port 0.
  - Response: pkt_cnt_0 reaches 15 then wraps to 0.
